acc_stream: RTL and testbench
=============================

ACC_STREAM -- requirements
Module: acc_stream

Interface
REQ-001 Parameter N, default 8: operand and accumulator width in bits (N >= 2).
REQ-002 Parameter CNT_W, default 4: width of the operand-count field.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin a new accumulation; sampled only in IDLE.
REQ-006 len  input  CNT_W  number of operands to accumulate; sampled with start.
REQ-007 in_valid  input  1  in_data holds a valid operand.
REQ-008 in_ready  output  1  block accepts an operand this cycle.
REQ-009 in_data  input  N  two's-complement operand.
REQ-010 out_valid  output  1  result fields valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_sum  output  N  accumulated sum.
REQ-013 out_carry  output  1  sticky OR of every adder carry-out in this run.
REQ-014 out_overflow  output  1  sticky signed overflow (carry into MSB XOR carry-out) in this run.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCUM, DONE.
REQ-017 IDLE, start=1, len>0: clear accumulator and sticky flags, load remaining count = len, go to ACCUM next cycle.
REQ-018 IDLE, start=1, len=0: clear accumulator and flags, go directly to DONE (result 0, flags 0).
REQ-019 in_ready SHALL be 1 only in ACCUM; an operand is accepted on a cycle with in_valid=1 and in_ready=1.
REQ-020 On acceptance: accumulator <= accumulator + in_data (N-bit, carry-in 0); flags OR-in this addition's carry and overflow; count decrements.
REQ-021 When the operand accepted makes count reach 0, the next state SHALL be DONE; out_valid is 1 the cycle after the last acceptance (one-cycle latency).
REQ-022 in_valid=0 in ACCUM: state, accumulator and count hold; no timeout.
REQ-023 DONE: out_valid=1, out_sum/out_carry/out_overflow stable until out_valid&&out_ready; then go to IDLE next cycle.
REQ-024 start SHALL be ignored outside IDLE, including the DONE→IDLE handshake cycle.
REQ-025 Accumulation wraps modulo 2^N when saturation is not compiled in.
REQ-026 out_sum, out_carry, out_overflow SHALL remain driven with the last result while IDLE; cleared only by next start or reset.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, accumulator 0, count 0, flags 0.
REQ-028 Reset values: in_ready=0, out_valid=0, out_sum=0, out_carry=0, out_overflow=0, busy=0.
REQ-029 Reset asserted mid-ACCUM or mid-DONE SHALL discard the run; no partial result is presented.

Configuration
REQ-030 Macro ACC_STREAM_SATURATE_EN defined: on a step with signed overflow, accumulator SHALL clamp to 2^(N-1)-1 (positive overflow) or -2^(N-1) (negative overflow); out_overflow still sets.
REQ-031 Macro undefined: no clamp logic present; wrap-around per REQ-025.

Structure
REQ-032 Shared package acc_stream_pkg SHALL hold the state enumeration (IDLE, ACCUM, DONE) and the saturation max/min constant functions of N.
REQ-033 Addition SHALL use one instance of the team's CLA adder (parameter N, C_in tied 0), whose sum, C_out and overflow outputs feed the accumulator and sticky flags; no other sub-module.

Verification
REQ-034 N=8, len=3, operands 10,20,30 back-to-back -> out_valid 1 cycle after 3rd accept, out_sum=60, carry=0, overflow=0.
REQ-035 N=8, len=2, operands 100,100 -> wrap build: out_sum=0xC8 (-56), overflow=1, carry=0; SATURATE_EN build: out_sum=127, overflow=1.
REQ-036 N=8, len=2, operands 0xFF,0x01 -> out_sum=0x00, carry=1, overflow=0.
REQ-037 len=0 with start -> DONE next cycle, out_sum=0, no in_ready pulse; start during DONE ignored; out_ready held 0 for 5 cycles keeps outputs stable.
REQ-038 len=4, in_valid gaps between operands 1,2,3,4, rst_n pulsed low after 2nd accept -> all outputs 0 immediately; fresh start len=1 operand 5 -> out_sum=5.

Source files
------------

// File: rtl/acc_stream_pkg.sv
// acc_stream_pkg: FSM state encoding and saturation bounds shared by the acc_stream block.
package acc_stream_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;
  function automatic logic [63:0] sat_max(input int n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] sat_min(input int n);
    return 64'd1 << (n - 1);
  endfunction
endpackage

// File: rtl/acc_stream_cla.sv
// acc_stream_cla: N-bit generate/propagate adder with carry-out and signed overflow.
module acc_stream_cla #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         c_i,
  output logic [N-1:0] s_o,
  output logic         c_o,
  output logic         ovf_o
);
  logic [N-1:0] g, p;
  logic cy, cm;
  assign g = a_i & b_i;
  assign p = a_i ^ b_i;
  // cm ends up as the carry into the MSB, cy as the carry out of it
  always_comb begin
    cy = c_i;
    cm = 1'b0;
    s_o = '0;
    for (int i = 0; i < N; i++) begin
      s_o[i] = p[i] ^ cy;
      cm = cy;
      cy = g[i] | (p[i] & cy);
    end
  end
  assign c_o = cy;
  assign ovf_o = cy ^ cm;
endmodule

// File: rtl/acc_stream.sv
// acc_stream: counted streaming accumulator with sticky carry/overflow flags.
// Define ACC_STREAM_SATURATE_EN to clamp the accumulator on signed overflow instead of wrapping.
module acc_stream
  import acc_stream_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             busy
);
  state_e state_q;
  logic [N-1:0] acc_q, acc_d, sum;
  logic [CNT_W-1:0] cnt_q;
  logic carry_q, ovf_q, co, ov;
  acc_stream_cla #(.N(N)) u_add (
    .a_i  (acc_q),
    .b_i  (in_data),
    .c_i  (1'b0),
    .s_o  (sum),
    .c_o  (co),
    .ovf_o(ov)
  );
`ifdef ACC_STREAM_SATURATE_EN
  localparam logic [63:0] SMAX = sat_max(N);
  localparam logic [63:0] SMIN = sat_min(N);
  // a wrapped negative-looking sum means the true result overflowed upward
  assign acc_d = ov ? (sum[N-1] ? SMAX[N-1:0] : SMIN[N-1:0]) : sum;
`else
  assign acc_d = sum;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          acc_q   <= '0;
          carry_q <= 1'b0;
          ovf_q   <= 1'b0;
          cnt_q   <= len;
          state_q <= (len == '0) ? DONE : ACCUM;
        end
        ACCUM: if (in_valid) begin
          acc_q   <= acc_d;
          carry_q <= carry_q | co;
          ovf_q   <= ovf_q | ov;
          cnt_q   <= cnt_q - 1'b1;
          state_q <= (cnt_q == CNT_W'(1)) ? DONE : ACCUM;
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready     = state_q == ACCUM;
  assign out_valid    = state_q == DONE;
  assign busy         = state_q != IDLE;
  assign out_sum      = acc_q;
  assign out_carry    = carry_q;
  assign out_overflow = ovf_q;
endmodule

// File: tb/tb_acc_stream.sv
// tb_acc_stream: directed self-checking bench for acc_stream (N=8, CNT_W=4).
module tb_acc_stream;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] len = '0;
  logic [7:0] in_data = '0;
  logic in_ready, out_valid, out_carry, out_overflow, busy;
  logic [7:0] out_sum;
  int total = 0, bad = 0;

  acc_stream #(.N(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_carry(out_carry), .out_overflow(out_overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic do_start(input logic [3:0] l);
    start = 1'b1;
    len = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({in_ready, out_valid, out_sum, out_carry, out_overflow, busy} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs got %b want 0", {in_ready, out_valid, out_sum, out_carry, out_overflow, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle busy got %b want 0", busy); end
  endtask

  task automatic test_accum();
    do_start(4'd3);
    total++;
    if ({in_ready, busy} !== 2'b11) begin bad++; $display("FAIL accum_ready got %b want 11", {in_ready, busy}); end
    send(8'd10);
    send(8'd20);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL accum_early_valid got %b want 0", out_valid); end
    send(8'd30);
    total++;
    if ({out_valid, in_ready} !== 2'b10) begin bad++; $display("FAIL accum_valid got %b want 10", {out_valid, in_ready}); end
    total++;
    if ({out_sum, out_carry, out_overflow} !== {8'd60, 2'b00}) begin
      bad++;
      $display("FAIL accum_result got %h/%b/%b want 3c/0/0", out_sum, out_carry, out_overflow);
    end
    drain();
    total++;
    if ({busy, out_valid, out_sum} !== {2'b00, 8'd60}) begin
      bad++;
      $display("FAIL accum_idle_hold got %b/%b/%h want 0/0/3c", busy, out_valid, out_sum);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_a, exp_b;
`ifdef ACC_STREAM_SATURATE_EN
    exp_a = 8'd127;
    exp_b = 8'h85;
`else
    exp_a = 8'hC8;
    exp_b = 8'h05;
`endif
    do_start(4'd2);
    send(8'd100);
    send(8'd100);
    total++;
    if ({out_valid, out_sum, out_carry, out_overflow} !== {1'b1, exp_a, 2'b01}) begin
      bad++;
      $display("FAIL ovf_pos got %b/%h/%b/%b want 1/%h/0/1", out_valid, out_sum, out_carry, out_overflow, exp_a);
    end
    drain();
    do_start(4'd3);
    send(8'h80);
    send(8'h80);
    send(8'h05);
    total++;
    if ({out_sum, out_carry, out_overflow} !== {exp_b, 2'b11}) begin
      bad++;
      $display("FAIL ovf_sticky got %h/%b/%b want %h/1/1", out_sum, out_carry, out_overflow, exp_b);
    end
    drain();
  endtask

  task automatic test_carry();
    do_start(4'd2);
    send(8'hFF);
    send(8'h01);
    total++;
    if ({out_valid, out_sum, out_carry, out_overflow} !== {1'b1, 8'h00, 2'b10}) begin
      bad++;
      $display("FAIL carry got %b/%h/%b/%b want 1/00/1/0", out_valid, out_sum, out_carry, out_overflow);
    end
    drain();
  endtask

  task automatic test_len_zero();
    logic saw_ready;
    saw_ready = in_ready;
    start = 1'b1;
    len = 4'd0;
    @(negedge clk);
    start = 1'b0;
    saw_ready |= in_ready;
    total++;
    if ({out_valid, out_sum, out_carry, out_overflow, saw_ready} !== 12'b1_00000000_000) begin
      bad++;
      $display("FAIL len0_done got %b/%h/%b/%b rdy=%b want 1/00/0/0 rdy=0", out_valid, out_sum, out_carry, out_overflow, saw_ready);
    end
    start = 1'b1;
    len = 4'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({out_valid, in_ready, out_sum} !== {2'b10, 8'h00}) begin
        bad++;
        $display("FAIL len0_hold cyc%0d got %b/%b/%h want 1/0/00", i, out_valid, in_ready, out_sum);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    total++;
    if ({busy, out_valid, in_ready} !== 3'b000) begin
      bad++;
      $display("FAIL len0_handshake_start got %b want 000", {busy, out_valid, in_ready});
    end
  endtask

  task automatic test_reset_mid();
    do_start(4'd4);
    send(8'd1);
    @(negedge clk);
    total++;
    if ({in_ready, out_sum} !== {1'b1, 8'd1}) begin
      bad++;
      $display("FAIL gap_hold got %b/%h want 1/01", in_ready, out_sum);
    end
    send(8'd2);
    total++;
    if ({busy, out_sum} !== {1'b1, 8'd3}) begin
      bad++;
      $display("FAIL two_accepts got %b/%h want 1/03", busy, out_sum);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, out_sum, out_carry, out_overflow, busy} !== 13'd0) begin
      bad++;
      $display("FAIL mid_reset got %b want 0", {in_ready, out_valid, out_sum, out_carry, out_overflow, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(4'd1);
    send(8'd5);
    total++;
    if ({out_valid, out_sum, out_carry, out_overflow} !== {1'b1, 8'd5, 2'b00}) begin
      bad++;
      $display("FAIL after_reset got %b/%h/%b/%b want 1/05/0/0", out_valid, out_sum, out_carry, out_overflow);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    do_start(4'd1);
    send(8'hF6);
    drain();
    do_start(4'd2);
    send(8'd7);
    send(8'd3);
    total++;
    if ({out_valid, out_sum, out_carry, out_overflow} !== {1'b1, 8'd10, 2'b00}) begin
      bad++;
      $display("FAIL back_to_back got %b/%h/%b/%b want 1/0a/0/0", out_valid, out_sum, out_carry, out_overflow);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_accum();
    test_overflow();
    test_carry();
    test_len_zero();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
